// File: rtl/axi_ddr_pkg.sv
// axi_ddr_pkg: scheduler state encoding, burst constants and round-robin search
package axi_ddr_pkg;
    typedef enum logic [1:0] {IDLE, ARB, REQ, WAIT} sched_st_t;
    localparam int BURST_LEN   = 64;
    localparam int BEAT_BYTES  = 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam logic MODE_WR = 1'b0;
    localparam logic MODE_RD = 1'b1;
    function automatic int rr_next(input logic [7:0] elig, input int last, input int n);
        int r;
        r = (last + 1) % n;
        for (int k = 8; k >= 1; k--)
            if (k <= n && elig[(last + k) % n]) r = (last + k) % n;
        return r;
    endfunction
endpackage

// File: rtl/axi_ddr_mc_arb_if.sv
// axi_ddr_mc_arb_if: burst request/completion handshake to the axi write/read masters
interface axi_ddr_mc_arb_if #(parameter int ADDR_W = 32, LEN_W = 10, CH_W = 2);
    logic              wr_brust_req;
    logic [ADDR_W-1:0] wr_brust_addr;
    logic [LEN_W-1:0]  wr_brust_len;
    logic [CH_W-1:0]   wr_ch_sel;
    logic              wr_ready;
    logic              wr_brust_finish;
    logic              rd_brust_req;
    logic [ADDR_W-1:0] rd_brust_addr;
    logic [LEN_W-1:0]  rd_brust_len;
    logic [CH_W-1:0]   rd_ch_sel;
    logic              rd_ready;
    logic              rd_brust_finish;
    modport master(
        output wr_brust_req, wr_brust_addr, wr_brust_len, wr_ch_sel,
        output rd_brust_req, rd_brust_addr, rd_brust_len, rd_ch_sel,
        input  wr_ready, wr_brust_finish, rd_ready, rd_brust_finish
    );
    modport slave(
        input  wr_brust_req, wr_brust_addr, wr_brust_len, wr_ch_sel,
        input  rd_brust_req, rd_brust_addr, rd_brust_len, rd_ch_sel,
        output wr_ready, wr_brust_finish, rd_ready, rd_brust_finish
    );
endinterface

// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched: round-robin burst scheduler owning per-channel offset, bank and pending reset
module ddr_burst_sched
    import axi_ddr_pkg::*;
#(
    parameter logic MODE = MODE_WR,
    parameter int CH_NUM = 4,
    parameter int CH_W = 2,
    parameter int ADDR_W = 32,
    parameter int LEN_W = 10,
    parameter int CNT_W = 11,
    parameter int BLEN = BURST_LEN,
    parameter int BBYTES = BURST_BYTES,
    parameter logic [ADDR_W-1:0] PP_OFFSET = 32'h0080_0000
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        pingpang,
    input  logic [CH_NUM-1:0]        en,
    input  logic [CH_NUM-1:0]        ch_rst,
    input  logic [CH_NUM-1:0]        peer_bank,
    input  logic [CH_NUM*ADDR_W-1:0] b_flat,
    input  logic [CH_NUM*ADDR_W-1:0] e_flat,
    input  logic [CH_NUM*CNT_W-1:0]  lvl_flat,
    output logic [CH_NUM-1:0]        frame_done,
    output logic [CH_NUM-1:0]        bank,
    output logic                     req,
    output logic [ADDR_W-1:0]        addr,
    output logic [LEN_W-1:0]         len,
    output logic [CH_W-1:0]          sel,
    input  logic                     ready,
    input  logic                     finish
);
    sched_st_t st, nx;
    logic [ADDR_W-1:0] b [CH_NUM];
    logic [ADDR_W-1:0] e [CH_NUM];
    logic [ADDR_W-1:0] off [CH_NUM];
    logic [ADDR_W-1:0] nxt [CH_NUM];
    logic [CH_NUM-1:0] elig, pend;
    logic [CH_W-1:0] last, g;
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            b[i] = b_flat[i*ADDR_W +: ADDR_W];
            e[i] = e_flat[i*ADDR_W +: ADDR_W];
            nxt[i] = off[i] + ADDR_W'(BBYTES);
            elig[i] = (MODE == MODE_WR || en[i]) && lvl_flat[i*CNT_W +: CNT_W] >= CNT_W'(BLEN);
        end
        g = CH_W'(rr_next(8'(elig), int'(last), CH_NUM));
    end
    always_ff @(posedge clk) st <= rst ? IDLE : nx;
    always_comb begin
        nx = st;
        req = 1'b0;
        case (st)
            IDLE: nx = |elig ? ARB : IDLE;
            ARB:  nx = elig[g] ? REQ : IDLE;
            REQ: begin
                req = ready;
                nx = ready ? WAIT : REQ;
            end
            WAIT: nx = finish ? IDLE : WAIT;
            default: nx = IDLE;
        endcase
    end
    // A reset arriving while a channel's burst is in flight is deferred to that burst's finish
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= CH_W'(CH_NUM - 1);
            sel <= '0;
            addr <= '0;
            len <= '0;
            frame_done <= '0;
            bank <= '0;
            pend <= '0;
            for (int i = 0; i < CH_NUM; i++) off[i] <= '0;
        end else begin
            frame_done <= '0;
            if (st == ARB) begin
                last <= g;
                sel <= g;
                addr <= b[g] + (bank[g] ? PP_OFFSET : '0) + off[g];
                len <= LEN_W'(BLEN);
            end
            for (int i = 0; i < CH_NUM; i++) begin
                if (st == WAIT && finish && sel == CH_W'(i)) begin
                    pend[i] <= 1'b0;
                    if (pend[i] || ch_rst[i]) off[i] <= '0;
                    else if (b[i] + nxt[i] >= e[i]) begin
                        off[i] <= '0;
                        frame_done[i] <= MODE == MODE_WR;
                        if (pingpang[i]) bank[i] <= MODE == MODE_WR ? ~bank[i] : ~peer_bank[i];
                    end else off[i] <= nxt[i];
                end else if (ch_rst[i]) begin
                    if ((st == REQ || st == WAIT) && sel == CH_W'(i)) pend[i] <= 1'b1;
                    else off[i] <= '0;
                end
                if (!pingpang[i]) bank[i] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/axi_ddr_mc_arb.sv
// axi_ddr_mc_arb: N-channel DDR burst scheduler with independent write and read arbitration
module axi_ddr_mc_arb #(
    parameter int CH_NUM = 4,
    parameter int CH_W = 2,
    parameter int ADDR_W = 32,
    parameter int LEN_W = 10,
    parameter int BURST_LEN = axi_ddr_pkg::BURST_LEN,
    parameter int BEAT_BYTES = axi_ddr_pkg::BEAT_BYTES,
    parameter int CNT_W = 11,
    parameter logic [ADDR_W-1:0] PP_OFFSET = 32'h0080_0000
)(
    input  logic                     ui_clk,
    input  logic                     ui_rst,
    input  logic [CH_NUM-1:0]        ch_pingpang,
    input  logic [CH_NUM*ADDR_W-1:0] ch_wr_b_addr,
    input  logic [CH_NUM*ADDR_W-1:0] ch_wr_e_addr,
    input  logic [CH_NUM*CNT_W-1:0]  ch_wr_fifo_cnt,
    input  logic [CH_NUM-1:0]        ch_wr_rst,
    input  logic [CH_NUM*ADDR_W-1:0] ch_rd_b_addr,
    input  logic [CH_NUM*ADDR_W-1:0] ch_rd_e_addr,
    input  logic [CH_NUM*CNT_W-1:0]  ch_rd_fifo_space,
    input  logic [CH_NUM-1:0]        ch_rd_rst,
    input  logic [CH_NUM-1:0]        ch_rd_enable,
    output logic [CH_NUM-1:0]        ch_wr_frame_done,
    output logic [CH_NUM-1:0]        ch_rd_bank,
    axi_ddr_mc_arb_if.master         bus
);
    logic [CH_NUM-1:0] wr_bank, rd_done_unused;
    ddr_burst_sched #(
        .MODE(axi_ddr_pkg::MODE_WR), .CH_NUM(CH_NUM), .CH_W(CH_W), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .CNT_W(CNT_W), .BLEN(BURST_LEN), .BBYTES(BURST_LEN * BEAT_BYTES),
        .PP_OFFSET(PP_OFFSET)
    ) u_wr (
        .clk(ui_clk), .rst(ui_rst), .pingpang(ch_pingpang), .en({CH_NUM{1'b1}}),
        .ch_rst(ch_wr_rst), .peer_bank(ch_rd_bank), .b_flat(ch_wr_b_addr),
        .e_flat(ch_wr_e_addr), .lvl_flat(ch_wr_fifo_cnt), .frame_done(ch_wr_frame_done),
        .bank(wr_bank), .req(bus.wr_brust_req), .addr(bus.wr_brust_addr),
        .len(bus.wr_brust_len), .sel(bus.wr_ch_sel), .ready(bus.wr_ready),
        .finish(bus.wr_brust_finish)
    );
    ddr_burst_sched #(
        .MODE(axi_ddr_pkg::MODE_RD), .CH_NUM(CH_NUM), .CH_W(CH_W), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .CNT_W(CNT_W), .BLEN(BURST_LEN), .BBYTES(BURST_LEN * BEAT_BYTES),
        .PP_OFFSET(PP_OFFSET)
    ) u_rd (
        .clk(ui_clk), .rst(ui_rst), .pingpang(ch_pingpang), .en(ch_rd_enable),
        .ch_rst(ch_rd_rst), .peer_bank(wr_bank), .b_flat(ch_rd_b_addr),
        .e_flat(ch_rd_e_addr), .lvl_flat(ch_rd_fifo_space), .frame_done(rd_done_unused),
        .bank(ch_rd_bank), .req(bus.rd_brust_req), .addr(bus.rd_brust_addr),
        .len(bus.rd_brust_len), .sel(bus.rd_ch_sel), .ready(bus.rd_ready),
        .finish(bus.rd_brust_finish)
    );
endmodule

// File: tb/tb_axi_ddr_mc_arb.sv
// tb_axi_ddr_mc_arb: directed scenario bench for the N-channel burst scheduler
module tb_axi_ddr_mc_arb;
    localparam int CH_NUM = 4, CH_W = 2, ADDR_W = 32, LEN_W = 10, CNT_W = 11;
    logic clk = 1'b0;
    logic rst;
    logic [CH_NUM-1:0] pingpang, wr_rst, rd_rst, rd_en;
    logic [CH_NUM*ADDR_W-1:0] wr_b, wr_e, rd_b, rd_e;
    logic [CH_NUM*CNT_W-1:0] cnt, space;
    logic [CH_NUM-1:0] frame_done, rd_bank;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    axi_ddr_mc_arb_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CH_W(CH_W)) bus();
    axi_ddr_mc_arb #(.CH_NUM(CH_NUM), .CH_W(CH_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .ui_clk(clk), .ui_rst(rst), .ch_pingpang(pingpang),
        .ch_wr_b_addr(wr_b), .ch_wr_e_addr(wr_e), .ch_wr_fifo_cnt(cnt), .ch_wr_rst(wr_rst),
        .ch_rd_b_addr(rd_b), .ch_rd_e_addr(rd_e), .ch_rd_fifo_space(space), .ch_rd_rst(rd_rst),
        .ch_rd_enable(rd_en), .ch_wr_frame_done(frame_done), .ch_rd_bank(rd_bank), .bus(bus.master)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        pingpang = '0; wr_rst = '0; rd_rst = '0; rd_en = '0;
        wr_b = '0; wr_e = '0; rd_b = '0; rd_e = '0; cnt = '0; space = '0;
        bus.wr_ready = 1'b1; bus.rd_ready = 1'b1;
        bus.wr_brust_finish = 1'b0; bus.rd_brust_finish = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask
    task automatic wait_req(input logic rd, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if ((rd ? bus.rd_brust_req : bus.wr_brust_req) === 1'b1) ok = 1'b1;
            else tick;
        end
    endtask
    task automatic finish_burst(input logic rd);
        tick;
        if (rd) bus.rd_brust_finish = 1'b1; else bus.wr_brust_finish = 1'b1;
        tick;
        bus.rd_brust_finish = 1'b0;
        bus.wr_brust_finish = 1'b0;
    endtask
    task automatic burst(input logic rd, output logic ok, output logic [31:0] a, output logic [1:0] s);
        wait_req(rd, ok);
        a = rd ? bus.rd_brust_addr : bus.wr_brust_addr;
        s = rd ? bus.rd_ch_sel : bus.wr_ch_sel;
        finish_burst(rd);
    endtask
    task automatic test_reset;
        do_reset;
        rst = 1'b1;
        cnt = {CH_NUM{11'd64}};
        tick;
        total++; if (bus.wr_brust_req !== 1'b0) begin bad++; $display("FAIL rst_wr_req got=%b want=0", bus.wr_brust_req); end
        total++; if (bus.wr_brust_addr !== 32'h0) begin bad++; $display("FAIL rst_wr_addr got=%h want=0", bus.wr_brust_addr); end
        total++; if (bus.wr_brust_len !== 10'd0) begin bad++; $display("FAIL rst_wr_len got=%0d want=0", bus.wr_brust_len); end
        total++; if (bus.wr_ch_sel !== 2'd0) begin bad++; $display("FAIL rst_wr_sel got=%0d want=0", bus.wr_ch_sel); end
        total++; if (bus.rd_brust_req !== 1'b0) begin bad++; $display("FAIL rst_rd_req got=%b want=0", bus.rd_brust_req); end
        total++; if (bus.rd_brust_addr !== 32'h0) begin bad++; $display("FAIL rst_rd_addr got=%h want=0", bus.rd_brust_addr); end
        total++; if (frame_done !== 4'b0) begin bad++; $display("FAIL rst_frame_done got=%b want=0000", frame_done); end
        total++; if (rd_bank !== 4'b0) begin bad++; $display("FAIL rst_rd_bank got=%b want=0000", rd_bank); end
    endtask
    task automatic test_single_write;
        logic ok;
        logic [31:0] a;
        logic [1:0] s;
        do_reset;
        wr_e[31:0] = 32'h2000;
        cnt[10:0] = 11'd64;
        tick;
        total++; if (bus.wr_brust_req !== 1'b0) begin bad++; $display("FAIL single_lat1 got=%b want=0", bus.wr_brust_req); end
        tick;
        total++; if (bus.wr_brust_req !== 1'b1) begin bad++; $display("FAIL single_req got=%b want=1", bus.wr_brust_req); end
        total++; if (bus.wr_brust_addr !== 32'h0) begin bad++; $display("FAIL single_addr got=%h want=0", bus.wr_brust_addr); end
        total++; if (bus.wr_brust_len !== 10'd64) begin bad++; $display("FAIL single_len got=%0d want=64", bus.wr_brust_len); end
        total++; if (bus.wr_ch_sel !== 2'd0) begin bad++; $display("FAIL single_sel got=%0d want=0", bus.wr_ch_sel); end
        tick;
        total++; if (bus.wr_brust_req !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b want=0", bus.wr_brust_req); end
        bus.wr_brust_finish = 1'b1;
        tick;
        bus.wr_brust_finish = 1'b0;
        total++; if (bus.wr_brust_len !== 10'd64) begin bad++; $display("FAIL single_hold_len got=%0d want=64", bus.wr_brust_len); end
        burst(1'b0, ok, a, s);
        total++; if (!ok || a !== 32'h200) begin bad++; $display("FAIL single_next_addr ok=%b got=%h want=00000200", ok, a); end
        cnt = '0;
    endtask
    task automatic test_round_robin;
        logic ok;
        logic [31:0] a;
        logic [1:0] s;
        logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] exp_a [5] = '{32'h0, 32'h10000, 32'h20000, 32'h30000, 32'h200};
        do_reset;
        for (int i = 0; i < CH_NUM; i++) begin
            wr_b[i*32 +: 32] = 32'(i) << 16;
            wr_e[i*32 +: 32] = (32'(i) << 16) + 32'h2000;
            cnt[i*11 +: 11] = 11'd64;
        end
        for (int k = 0; k < 5; k++) begin
            burst(1'b0, ok, a, s);
            total++; if (!ok || s !== exp_s[k] || a !== exp_a[k]) begin bad++; $display("FAIL rr_grant%0d ok=%b got sel=%0d addr=%h want sel=%0d addr=%h", k, ok, s, a, exp_s[k], exp_a[k]); end
        end
        cnt = '0;
    endtask
    task automatic test_pingpang;
        logic ok;
        logic [31:0] a;
        logic [1:0] s;
        do_reset;
        pingpang[1] = 1'b1;
        rd_b[63:32] = 32'h1000;
        rd_e[63:32] = 32'h1200;
        rd_en[1] = 1'b1;
        space[21:11] = 11'd64;
        burst(1'b1, ok, a, s);
        total++; if (!ok || a !== 32'h1000 || s !== 2'd1) begin bad++; $display("FAIL pp_rd_burst ok=%b got addr=%h sel=%0d want addr=00001000 sel=1", ok, a, s); end
        total++; if (rd_bank !== 4'b0010) begin bad++; $display("FAIL pp_rd_bank got=%b want=0010", rd_bank); end
        rd_en = '0;
        wr_b[63:32] = 32'h1000;
        wr_e[63:32] = 32'h1400;
        cnt[21:11] = 11'd64;
        burst(1'b0, ok, a, s);
        total++; if (!ok || a !== 32'h1000 || s !== 2'd1) begin bad++; $display("FAIL pp_burst0 ok=%b got addr=%h sel=%0d want addr=00001000 sel=1", ok, a, s); end
        total++; if (frame_done !== 4'b0) begin bad++; $display("FAIL pp_no_done got=%b want=0000", frame_done); end
        burst(1'b0, ok, a, s);
        total++; if (!ok || a !== 32'h1200) begin bad++; $display("FAIL pp_burst1 ok=%b got=%h want=00001200", ok, a); end
        total++; if (frame_done !== 4'b0010) begin bad++; $display("FAIL pp_done_pulse got=%b want=0010", frame_done); end
        tick;
        total++; if (frame_done !== 4'b0) begin bad++; $display("FAIL pp_done_clear got=%b want=0000", frame_done); end
        burst(1'b0, ok, a, s);
        total++; if (!ok || a !== 32'h0080_1000) begin bad++; $display("FAIL pp_bank1 ok=%b got=%h want=00801000", ok, a); end
        cnt = '0;
    endtask
    task automatic test_read_gate;
        logic seen;
        do_reset;
        rd_b[31:0] = 32'h4000;
        rd_e[31:0] = 32'h8000;
        space[10:0] = 11'd64;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin tick; seen |= bus.rd_brust_req; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rd_disabled got=%b want=0", seen); end
        rd_en[0] = 1'b1;
        space[10:0] = 11'd63;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin tick; seen |= bus.rd_brust_req; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rd_space63 got=%b want=0", seen); end
        space[10:0] = 11'd64;
        tick;
        total++; if (bus.rd_brust_req !== 1'b0) begin bad++; $display("FAIL rd_lat1 got=%b want=0", bus.rd_brust_req); end
        tick;
        total++; if (bus.rd_brust_req !== 1'b1) begin bad++; $display("FAIL rd_req got=%b want=1", bus.rd_brust_req); end
        total++; if (bus.rd_brust_addr !== 32'h4000) begin bad++; $display("FAIL rd_addr got=%h want=00004000", bus.rd_brust_addr); end
        total++; if (bus.rd_brust_len !== 10'd64) begin bad++; $display("FAIL rd_len got=%0d want=64", bus.rd_brust_len); end
        total++; if (bus.wr_brust_req !== 1'b0) begin bad++; $display("FAIL rd_no_wr got=%b want=0", bus.wr_brust_req); end
        finish_burst(1'b1);
        space = '0;
    endtask
    task automatic test_wr_rst;
        logic ok;
        logic [31:0] a;
        logic [1:0] s;
        do_reset;
        wr_b[95:64] = 32'h30000;
        wr_e[95:64] = 32'h32000;
        cnt[32:22] = 11'd64;
        burst(1'b0, ok, a, s);
        burst(1'b0, ok, a, s);
        wait_req(1'b0, ok);
        total++; if (!ok || bus.wr_brust_addr !== 32'h30400 || bus.wr_ch_sel !== 2'd2) begin bad++; $display("FAIL wrst_third ok=%b got addr=%h sel=%0d want addr=00030400 sel=2", ok, bus.wr_brust_addr, bus.wr_ch_sel); end
        tick;
        wr_rst[2] = 1'b1;
        tick;
        wr_rst = '0;
        tick;
        bus.wr_brust_finish = 1'b1;
        tick;
        bus.wr_brust_finish = 1'b0;
        total++; if (frame_done !== 4'b0) begin bad++; $display("FAIL wrst_no_done got=%b want=0000", frame_done); end
        burst(1'b0, ok, a, s);
        total++; if (!ok || a !== 32'h30000) begin bad++; $display("FAIL wrst_pending ok=%b got=%h want=00030000", ok, a); end
        cnt = '0;
        tick;
        wr_rst[2] = 1'b1;
        tick;
        wr_rst = '0;
        cnt[32:22] = 11'd64;
        burst(1'b0, ok, a, s);
        total++; if (!ok || a !== 32'h30000) begin bad++; $display("FAIL wrst_idle ok=%b got=%h want=00030000", ok, a); end
        cnt = '0;
    endtask
    task automatic test_reset_in_wait;
        logic ok;
        logic [31:0] a;
        logic [1:0] s;
        do_reset;
        wr_b[31:0] = 32'h50000;
        wr_e[31:0] = 32'h52000;
        wr_b[63:32] = 32'h60000;
        wr_e[63:32] = 32'h62000;
        cnt[21:11] = 11'd64;
        wait_req(1'b0, ok);
        total++; if (!ok || bus.wr_ch_sel !== 2'd1) begin bad++; $display("FAIL rw_grant1 ok=%b got=%0d want=1", ok, bus.wr_ch_sel); end
        tick;
        rst = 1'b1;
        tick;
        total++; if (bus.wr_brust_req !== 1'b0) begin bad++; $display("FAIL rw_req got=%b want=0", bus.wr_brust_req); end
        total++; if (bus.wr_brust_addr !== 32'h0) begin bad++; $display("FAIL rw_addr got=%h want=0", bus.wr_brust_addr); end
        total++; if (bus.wr_brust_len !== 10'd0) begin bad++; $display("FAIL rw_len got=%0d want=0", bus.wr_brust_len); end
        total++; if (bus.wr_ch_sel !== 2'd0) begin bad++; $display("FAIL rw_sel got=%0d want=0", bus.wr_ch_sel); end
        rst = 1'b0;
        cnt[10:0] = 11'd64;
        burst(1'b0, ok, a, s);
        total++; if (!ok || s !== 2'd0 || a !== 32'h50000) begin bad++; $display("FAIL rw_first_after ok=%b got sel=%0d addr=%h want sel=0 addr=00050000", ok, s, a); end
        cnt = '0;
    endtask
    initial begin
        test_reset;
        test_single_write;
        test_round_robin;
        test_pingpang;
        test_read_gate;
        test_wr_rst;
        test_reset_in_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
